// File: rtl/fifo_reader.sv
// fifo_reader
//
// Read-side companion of the team FIFO. It pops words from the FIFO, packs
// WORDS consecutive words into one wide beat (first word in the least
// significant slot) and offers that beat on a valid/ready stream.
//
// Parameters:
//   WIDTH      FIFO word width
//   WORDS      FIFO words per output beat (>= 1)
//   CNT_WIDTH  width of the completed-beat counter (counter build only)
//
// Ports:
//   clk            sole clock, rising edge
//   reset          asynchronous, active-low reset
//   io_fifo_dout   FIFO head word, valid while io_fifo_empty = 0
//   io_fifo_empty  FIFO empty flag
//   io_fifo_pop    pop request to the FIFO (combinational)
//   io_out_data    packed beat (registered)
//   io_out_valid   beat available (registered)
//   io_out_ready   consumer accepts the beat
//   io_busy        a partial beat is being filled
//   io_beat_count  completed handshake count (only with FIFO_READER_COUNT_EN)
//
// Build option:
//   FIFO_READER_COUNT_EN  when defined, adds io_beat_count and its register.
module fifo_reader #(
  parameter int WIDTH     = 2,
  parameter int WORDS     = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       io_fifo_dout,
  input  logic                   io_fifo_empty,
  output logic                   io_fifo_pop,
  output logic [WIDTH*WORDS-1:0] io_out_data,
  output logic                   io_out_valid,
  input  logic                   io_out_ready,
  output logic                   io_busy
`ifdef FIFO_READER_COUNT_EN
  ,
  output logic [CNT_WIDTH-1:0]   io_beat_count
`endif
);

  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [WIDTH*WORDS-1:0] data_q, data_d;
  logic                   pop;
  logic                   last_pop;

  // Pops are allowed while filling, or while holding a beat that the
  // consumer takes this cycle, so the next beat's fill overlaps the
  // handshake. Reset gates the pop so nothing is drained during reset.
  assign pop = reset && !io_fifo_empty && ((state_q == FILL) || io_out_ready);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    data_d   = data_q;
    last_pop = 1'b0;

    if (pop) begin
      data_d[idx_q*WIDTH +: WIDTH] = io_fifo_dout;
      if (idx_q == LAST_IDX) begin
        idx_d    = '0;
        last_pop = 1'b1;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end

    // A pop in HOLD can only complete a beat when WORDS = 1, in which case
    // the reader stays in HOLD and streams one beat per cycle.
    case (state_q)
      FILL:    if (last_pop) state_d = HOLD;
      HOLD:    if (io_out_ready) state_d = last_pop ? HOLD : FILL;
      default: state_d = FILL;
    endcase
  end

  // State, slot index and beat register. Reset throws away any words already
  // collected for a partial beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FILL;
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

  assign io_fifo_pop  = pop;
  assign io_out_data  = data_q;
  assign io_out_valid = (state_q == HOLD);
  assign io_busy      = (idx_q != '0);

`ifdef FIFO_READER_COUNT_EN
  logic [CNT_WIDTH-1:0] count_q, count_d;

  // Counts accepted beats; wraps naturally at 2^CNT_WIDTH.
  always_comb begin
    count_d = count_q;
    if (io_out_valid && io_out_ready) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

  assign io_beat_count = count_q;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader
//
// Bench for fifo_reader (WIDTH=2, WORDS=4, CNT_WIDTH=8). A queue-based model
// collects popped words into beats and tracks accepted handshakes; one
// process drives inputs after the falling edge, compares every output
// against the model, then advances the model at the rising edge.
module tb_fifo_reader;

  localparam int WIDTH     = 2;
  localparam int WORDS     = 4;
  localparam int CNT_WIDTH = 8;
  localparam int DW        = WIDTH * WORDS;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [WIDTH-1:0] io_fifo_dout = '0;
  logic             io_fifo_empty = 1'b1;
  logic             io_fifo_pop;
  logic [DW-1:0]    io_out_data;
  logic             io_out_valid;
  logic             io_out_ready = 1'b0;
  logic             io_busy;
`ifdef FIFO_READER_COUNT_EN
  logic [CNT_WIDTH-1:0] io_beat_count;
`endif

  fifo_reader #(
    .WIDTH    (WIDTH),
    .WORDS    (WORDS),
    .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .io_fifo_dout (io_fifo_dout),
    .io_fifo_empty(io_fifo_empty),
    .io_fifo_pop  (io_fifo_pop),
    .io_out_data  (io_out_data),
    .io_out_valid (io_out_valid),
    .io_out_ready (io_out_ready),
    .io_busy      (io_busy)
`ifdef FIFO_READER_COUNT_EN
    ,
    .io_beat_count(io_beat_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: words popped for the beat under construction, the
  // completed beat awaiting acceptance, and the number of accepted beats.
  logic [WIDTH-1:0] part_q[$];
  bit               holding;
  logic [DW-1:0]    beat;
  int               hs_count;
  bit               exp_pop;

  logic             pop_seen;
  logic             busy_seen;

  function automatic void check(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endfunction

  function automatic void model_reset();
    part_q.delete();
    holding  = 1'b0;
    beat     = '0;
    hs_count = 0;
  endfunction

  function automatic bit model_pop();
    return reset && !io_fifo_empty && (!holding || io_out_ready);
  endfunction

  // Advance the model by one rising edge using the inputs applied this cycle.
  function automatic void model_step();
    bit p;
    p = model_pop();
    if (holding && io_out_ready) begin
      holding = 1'b0;
      hs_count++;
    end
    if (p) begin
      part_q.push_back(io_fifo_dout);
      if (part_q.size() == WORDS) begin
        beat = '0;
        for (int i = 0; i < WORDS; i++)
          beat = beat | (DW'(part_q[i]) << (i * WIDTH));
        part_q.delete();
        holding = 1'b1;
      end
    end
  endfunction

  task automatic check_output();
    exp_pop = model_pop();
    check("pop", io_fifo_pop, exp_pop);
    check("valid", io_out_valid, holding);
    check("busy", io_busy, part_q.size() != 0);
    if (holding || !reset) check("data", io_out_data, beat);
`ifdef FIFO_READER_COUNT_EN
    check("beat_count", io_beat_count, CNT_WIDTH'(hs_count));
`endif
  endtask

  // One clock cycle: drive after the falling edge, compare, then let the
  // rising edge advance both the DUT and the model.
  task automatic apply_stimulus(input bit empty_v, input bit ready_v,
                                input logic [WIDTH-1:0] dout_v, input bit rst_n_v);
    @(negedge clk);
    reset         = rst_n_v;
    io_fifo_empty = empty_v;
    io_out_ready  = ready_v;
    io_fifo_dout  = dout_v;
    #1;
    if (!rst_n_v) model_reset();
    pop_seen  = io_fifo_pop;
    busy_seen = io_busy;
    check_output();
    @(posedge clk);
    if (rst_n_v) model_step();
  endtask

  logic [WIDTH-1:0] rnd_word;
  int               guard;

  initial begin
    model_reset();

    // Reset held with a non-empty FIFO.
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b1, 2'd1, 1'b0);
    check("reset_pop", pop_seen, 1'b0);
    #1;
    check("reset_valid", io_out_valid, 1'b0);
    check("reset_data", io_out_data, 8'h00);
    check("reset_busy", io_busy, 1'b0);

    // Packing: heads 1,2,3,0 straight after reset release.
    apply_stimulus(1'b0, 1'b1, 2'd1, 1'b1);
    check("pack_pop0", pop_seen, 1'b1);
    apply_stimulus(1'b0, 1'b1, 2'd2, 1'b1);
    apply_stimulus(1'b0, 1'b1, 2'd3, 1'b1);
    apply_stimulus(1'b0, 1'b1, 2'd0, 1'b1);
    check("pack_pop3", pop_seen, 1'b1);
    #1;
    check("pack_valid", io_out_valid, 1'b1);
    check("pack_data", io_out_data, 8'h39);

    // Backpressure for 10 cycles, then release with a same-cycle pop.
    for (int i = 0; i < 10; i++) begin
      rnd_word = WIDTH'($urandom);
      apply_stimulus(1'b0, 1'b0, rnd_word, 1'b1);
      check("bp_pop", pop_seen, 1'b0);
    end
    #1;
    check("bp_data", io_out_data, 8'h39);
    apply_stimulus(1'b0, 1'b1, 2'd2, 1'b1);
    check("bp_release_pop", pop_seen, 1'b1);
    #1;
    check("bp_release_valid", io_out_valid, 1'b0);
    check("bp_release_busy", io_busy, 1'b1);

    // Finish that beat, then drain it with the FIFO empty.
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b1, 2'd3, 1'b1);
    apply_stimulus(1'b1, 1'b1, 2'd0, 1'b1);

    // Empty gaps: FIFO alternates non-empty / empty.
    for (int i = 0; i < 8; i++) begin
      rnd_word = WIDTH'($urandom);
      apply_stimulus(i[0], i != 7, rnd_word, 1'b1);
      if (i == 3) check("gap_busy", busy_seen, 1'b1);
    end
    #1;
    check("gap_valid", io_out_valid, 1'b1);
    apply_stimulus(1'b1, 1'b1, 2'd0, 1'b1);

    // Mid-beat reset after two pops.
    apply_stimulus(1'b0, 1'b1, 2'd3, 1'b1);
    apply_stimulus(1'b0, 1'b1, 2'd3, 1'b1);
    apply_stimulus(1'b0, 1'b1, 2'd3, 1'b0);
    check("midrst_busy", busy_seen, 1'b0);
    check("midrst_pop", pop_seen, 1'b0);
    apply_stimulus(1'b0, 1'b1, 2'd2, 1'b1);
    apply_stimulus(1'b0, 1'b1, 2'd1, 1'b1);
    apply_stimulus(1'b0, 1'b1, 2'd0, 1'b1);
    apply_stimulus(1'b0, 1'b1, 2'd3, 1'b1);
    #1;
    check("midrst_valid", io_out_valid, 1'b1);
    check("midrst_data", io_out_data, 8'hC6);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rnd_word = WIDTH'($urandom);
      apply_stimulus($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
                     rnd_word, $urandom_range(0, 499) != 0);
    end

`ifdef FIFO_READER_COUNT_EN
    // Counter wrap: 300 accepted beats on an 8-bit counter.
    apply_stimulus(1'b1, 1'b0, 2'd0, 1'b0);
    guard = 0;
    while (hs_count < 300 && guard < 2000) begin
      rnd_word = WIDTH'($urandom);
      apply_stimulus(1'b0, 1'b1, rnd_word, 1'b1);
      guard++;
    end
    check("count_budget", guard < 2000, 1'b1);
    #1;
    check("count_300", io_beat_count, 8'd44);
`else
    guard = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
